// File: rtl/frame_buffer_arbiter_if.sv
// Signal bundle between the frame_buffer_arbiter and its scan path, host port and frame-buffer RAM.
// The slave modport is the arbiter; the master modport is whatever surrounds it.
interface frame_buffer_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24
);
  logic              frame_start;
  logic              scan_rd_req;
  logic [ADDR_W-1:0] scan_rd_addr;
  logic              scan_rd_valid;
  logic [DATA_W-1:0] scan_rd_data;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_swap_req;
  logic              host_swap_ack;
  logic              front_bank;
  logic [15:0]       frame_count;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output frame_start, scan_rd_req, scan_rd_addr,
    output host_wr_valid, host_wr_addr, host_wr_data, host_swap_req,
    output ram_rdata,
    input  scan_rd_valid, scan_rd_data, host_wr_ready, host_swap_ack,
    input  front_bank, frame_count, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  frame_start, scan_rd_req, scan_rd_addr,
    input  host_wr_valid, host_wr_addr, host_wr_data, host_swap_req,
    input  ram_rdata,
    output scan_rd_valid, scan_rd_data, host_wr_ready, host_swap_ack,
    output front_bank, frame_count, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Double-buffered frame-buffer arbiter: scan reads always win, host writes drain from a FIFO into the
// back bank, and bank swaps land only on a frame boundary. FB_FRAME_COUNT_EN builds the swap counter.
module frame_buffer_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_buffer_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              out_of_reset;
  logic              swap_pending;
  logic              front_bank;
  logic              swap_ack;
  logic              scan_pipe1;
  logic              scan_pipe2;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  logic              fifo_empty;
  logic              fifo_full;
  logic              host_ready;
  logic              push;
  logic              pop;
  logic              write_issuing;
  logic              do_swap;

  // Per-cycle handshake, pop and swap qualification
  always_comb begin
    fifo_empty    = (fifo_count == CNT_W'(0));
    fifo_full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    host_ready    = out_of_reset && !fifo_full && !swap_pending;
    push          = bus.host_wr_valid && host_ready;
    pop           = !bus.scan_rd_req && !fifo_empty;
    write_issuing = ram_en && ram_we;
    // A write still on the RAM bus belongs to the outgoing back bank, so it must land before the swap
    do_swap       = bus.frame_start && swap_pending && fifo_empty && !write_issuing;
  end

  // FIFO storage; occupancy gates every read, so the entries themselves need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.host_wr_addr;
      fifo_data[wr_ptr] <= bus.host_wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= PTR_W'(0);
      rd_ptr     <= PTR_W'(0);
      fifo_count <= CNT_W'(0);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // RAM port: scan read first, else a FIFO pop into the back bank as seen at pop time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= (ADDR_W + 1)'(0);
      ram_wdata <= DATA_W'(0);
    end else if (bus.scan_rd_req) begin
      ram_en   <= 1'b1;
      ram_we   <= 1'b0;
      ram_addr <= {front_bank, bus.scan_rd_addr};
    end else if (pop) begin
      ram_en    <= 1'b1;
      ram_we    <= 1'b1;
      ram_addr  <= {~front_bank, fifo_addr[rd_ptr]};
      ram_wdata <= fifo_data[rd_ptr];
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
    end
  end

  // Swap request, bank toggle and acknowledge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_of_reset <= 1'b0;
      swap_pending <= 1'b0;
      front_bank   <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      swap_ack     <= do_swap;
      if (do_swap) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
      end else if (bus.host_swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Scan valid follows the request through the RAM's one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_pipe1 <= 1'b0;
      scan_pipe2 <= 1'b0;
    end else begin
      scan_pipe1 <= bus.scan_rd_req;
      scan_pipe2 <= scan_pipe1;
    end
  end

`ifdef FB_FRAME_COUNT_EN
  logic [15:0] frame_count;

  // Completed-swap counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (do_swap) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign bus.frame_count = frame_count;
`else
  assign bus.frame_count = 16'd0;
`endif

  assign bus.host_wr_ready = host_ready;
  assign bus.host_swap_ack = swap_ack;
  assign bus.front_bank    = front_bank;
  assign bus.scan_rd_valid = scan_pipe2;
  assign bus.scan_rd_data  = bus.ram_rdata;
  assign bus.ram_en        = ram_en;
  assign bus.ram_we        = ram_we;
  assign bus.ram_addr      = ram_addr;
  assign bus.ram_wdata     = ram_wdata;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: a queue-based model of the arbiter rules checked every cycle,
// plus hand-computed literal expectations at the points the scenarios call out.
module tb_frame_buffer_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_buffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] seed(input logic [AW:0] a);
    logic [31:0] v;
    v = (32'(a) * 32'h0001_0101) ^ 32'h0000_A5C3;
    return v[DW-1:0];
  endfunction

  // RAM responder: unwritten words read back as seed(addr)
  logic [DW-1:0] ram_mem [2048];
  bit            ram_wr  [2048];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram_mem[bus.ram_addr] <= bus.ram_wdata;
        ram_wr[bus.ram_addr]  <= 1'b1;
      end else begin
        bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : seed(bus.ram_addr);
      end
    end
  end

  // Behavioural model
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           m_q[$];
  logic          m_alive = 1'b0, m_pending = 1'b0, m_front = 1'b0, m_ack = 1'b0;
  logic          m_en = 1'b0, m_we = 1'b0, m_v1 = 1'b0, m_v2 = 1'b0;
  logic [AW:0]   m_addr = '0, m_p1 = '0, m_p2 = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [15:0]   m_count = 16'd0;
  logic [DW-1:0] m_mem [2048];
  bit            m_wr  [2048];

  task automatic model_step();
    bit  ready, accept, swap;
    wr_t e;
    if (reset) begin
      m_q.delete();
      {m_alive, m_pending, m_front, m_ack, m_en, m_we, m_v1, m_v2} = 8'd0;
      m_count = 16'd0;
      return;
    end
    ready  = m_alive && (m_q.size() < DEPTH) && !m_pending;
    accept = bus.host_wr_valid && ready;
    swap   = bus.frame_start && m_pending && (m_q.size() == 0) && !(m_en && m_we);
    m_v2 = m_v1;  m_v1 = bus.scan_rd_req;
    m_p2 = m_p1;  m_p1 = {m_front, bus.scan_rd_addr};
    if (bus.scan_rd_req) begin
      m_en = 1'b1; m_we = 1'b0; m_addr = {m_front, bus.scan_rd_addr};
    end else if (m_q.size() != 0) begin
      e = m_q.pop_front();
      m_en = 1'b1; m_we = 1'b1; m_addr = {~m_front, e.a}; m_wdata = e.d;
      m_mem[m_addr] = e.d; m_wr[m_addr] = 1'b1;
    end else begin
      m_en = 1'b0; m_we = 1'b0;
    end
    if (accept) m_q.push_back('{bus.host_wr_addr, bus.host_wr_data});
    m_ack = swap;
    if (swap) begin
      m_front = ~m_front; m_pending = 1'b0; m_count = m_count + 16'd1;
    end else if (bus.host_swap_req) begin
      m_pending = 1'b1;
    end
    m_alive = 1'b1;
  endtask

  always @(posedge clk or posedge reset) model_step();

  function automatic logic [15:0] exp_count(input logic [15:0] c);
`ifdef FB_FRAME_COUNT_EN
    return c;
`else
    return 16'd0 & c;
`endif
  endfunction

  // Per-cycle compare, plus observation of writes and acks for the literal checks
  logic [AW:0] obs[$];
  int          ack_seen = 0;
  always @(negedge clk) begin
    chk("ram_en", 32'(bus.ram_en), 32'(m_en));
    chk("ram_we", 32'(bus.ram_we), 32'(m_we));
    if (m_en) chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
    if (m_we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
    chk("scan_rd_valid", 32'(bus.scan_rd_valid), 32'(m_v2));
    if (m_v2) chk("scan_rd_data", 32'(bus.scan_rd_data), 32'(m_wr[m_p2] ? m_mem[m_p2] : seed(m_p2)));
    chk("host_wr_ready", 32'(bus.host_wr_ready),
        32'(m_alive && (m_q.size() < DEPTH) && !m_pending));
    chk("host_swap_ack", 32'(bus.host_swap_ack), 32'(m_ack));
    chk("front_bank", 32'(bus.front_bank), 32'(m_front));
    chk("frame_count", 32'(bus.frame_count), 32'(exp_count(m_count)));
    if (bus.ram_en && bus.ram_we) obs.push_back(bus.ram_addr);
    if (bus.host_swap_ack) ack_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.host_wr_valid = 1'b1; bus.host_wr_addr = a; bus.host_wr_data = d;
    step(1);
    bus.host_wr_valid = 1'b0;
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    step(1);
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.frame_start = 1'b0; bus.scan_rd_req = 1'b0; bus.scan_rd_addr = '0;
    bus.host_wr_valid = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
    bus.host_swap_req = 1'b0;

    // Reset then idle
    step(3);
    chk("reset_ready", 32'(bus.host_wr_ready), 32'd0);
    chk("reset_front", 32'(bus.front_bank), 32'd0);
    reset = 1'b0;
    step(1);
    chk("ready_after_reset", 32'(bus.host_wr_ready), 32'd1);
    step(2);
    chk("idle_ram_en", 32'(bus.ram_en), 32'd0);

    // Scan burst 0..15
    bus.scan_rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.scan_rd_addr = AW'(i);
      step(1);
      if (i == 0) chk("burst_first_addr", 32'(bus.ram_addr), 32'h000);
    end
    bus.scan_rd_req = 1'b0;
    chk("burst_last_addr", 32'(bus.ram_addr), 32'h00F);
    step(1);
    chk("burst_last_valid", 32'(bus.scan_rd_valid), 32'd1);
    chk("burst_last_data", 32'(bus.scan_rd_data), 32'h0FAACC);
    step(2);

    // Five host writes against a continuous scan: four fit
    bus.scan_rd_req = 1'b1; bus.scan_rd_addr = 10'h3FF;
    for (int k = 0; k < 5; k++) host_write(AW'(10'h010 + k), DW'(24'hA00000 + k));
    chk("full_ready_low", 32'(bus.host_wr_ready), 32'd0);
    obs.delete();
    step(3);
    chk("starved_no_write", 32'(obs.size()), 32'd0);
    bus.scan_rd_req = 1'b0;
    step(6);
    chk("drain_count", 32'(obs.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs.size(); k++) chk("drain_addr", 32'(obs[k]), 32'h410 + 32'(k));

    // Swap blocked by a non-empty FIFO, completed at the next frame_start
    bus.scan_rd_req = 1'b1;
    host_write(10'h020, 24'h123456);
    host_write(10'h021, 24'h654321);
    bus.host_swap_req = 1'b1; step(1); bus.host_swap_req = 1'b0;
    step(2);
    pulse_frame_start();
    step(1);
    chk("blocked_no_ack", 32'(ack_seen), 32'd0);
    chk("blocked_front", 32'(bus.front_bank), 32'd0);
    bus.scan_rd_req = 1'b0;
    step(4);
    pulse_frame_start();
    chk("swap1_front", 32'(bus.front_bank), 32'd1);
    chk("swap1_ack", 32'(bus.host_swap_ack), 32'd1);
    chk("swap1_count", 32'(bus.frame_count), 32'(exp_count(16'd1)));
    step(1);
    chk("swap1_ack_once", 32'(ack_seen), 32'd1);

    // Reset with three queued writes and a pending swap
    bus.scan_rd_req = 1'b1;
    for (int k = 0; k < 3; k++) host_write(AW'(10'h030 + k), DW'(24'hB00000 + k));
    bus.host_swap_req = 1'b1; step(1); bus.host_swap_req = 1'b0;
    step(2);
    reset = 1'b1;
    #1;
    chk("midreset_front", 32'(bus.front_bank), 32'd0);
    chk("midreset_ram_en", 32'(bus.ram_en), 32'd0);
    step(2);
    bus.scan_rd_req = 1'b0;
    reset = 1'b0;
    obs.delete();
    step(8);
    chk("post_reset_no_write", 32'(obs.size()), 32'd0);
    chk("post_reset_ready", 32'(bus.host_wr_ready), 32'd1);

    // Swap request coincident with frame_start is deferred one frame
    bus.host_swap_req = 1'b1; bus.frame_start = 1'b1;
    step(1);
    bus.host_swap_req = 1'b0; bus.frame_start = 1'b0;
    chk("coincident_no_swap", 32'(bus.front_bank), 32'd0);
    step(3);
    pulse_frame_start();
    chk("deferred_front", 32'(bus.front_bank), 32'd1);
    chk("deferred_count", 32'(bus.frame_count), 32'(exp_count(16'd1)));
    step(2);
    chk("deferred_ack_total", 32'(ack_seen), 32'd2);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
